fp_op_sequencer: RTL

//  Sequences one decoded RV32F operation at a time through the shared multi-cycle FP ALU.
//  - Sits between the FP control unit (decode) and the FP ALU / register-file writeback.
//  - Accepts an op with a valid/ready handshake and starts the ALU.
//  - Counts out the op's fixed latency, latches the result and fflags, and presents it to writeback.
//  - Stalls decode while busy; supports pipeline flush.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_lat_lookup.sv | 29 ++
 rtl/fp_op_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP definitions: ALU op codes, sequencer state encoding, fflags bit order.
package fp_pkg;

  // FP ALU control codes (same encoding as the FP control unit)
  localparam logic [4:0] OP_ADD      = 5'b00000;
  localparam logic [4:0] OP_SUB      = 5'b00001;
  localparam logic [4:0] OP_MUL      = 5'b00010;
  localparam logic [4:0] OP_DIV      = 5'b00011;
  localparam logic [4:0] OP_SQRT     = 5'b00100;
  localparam logic [4:0] OP_MIN      = 5'b00101;
  localparam logic [4:0] OP_MAX      = 5'b00110;
  localparam logic [4:0] OP_MADD     = 5'b00111;
  localparam logic [4:0] OP_MSUB     = 5'b01000;
  localparam logic [4:0] OP_NMSUB    = 5'b01001;
  localparam logic [4:0] OP_NMADD    = 5'b01010;
  localparam logic [4:0] OP_SGNJ     = 5'b01011;
  localparam logic [4:0] OP_SGNJN    = 5'b01100;
  localparam logic [4:0] OP_SGNJX    = 5'b01101;
  localparam logic [4:0] OP_CVT_W_S  = 5'b01110;
  localparam logic [4:0] OP_CVT_WU_S = 5'b01111;
  localparam logic [4:0] OP_CVT_S_W  = 5'b10000;
  localparam logic [4:0] OP_CVT_S_WU = 5'b10001;
  localparam logic [4:0] OP_MV_X_W   = 5'b10010;
  localparam logic [4:0] OP_MV_W_X   = 5'b10011;
  localparam logic [4:0] OP_CLASS    = 5'b10100;
  localparam logic [4:0] OP_EQ       = 5'b10101;
  localparam logic [4:0] OP_LT       = 5'b10110;
  localparam logic [4:0] OP_LE       = 5'b10111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // fflags bit positions (fcsr order)
  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

endpackage

// File: rtl/fp_lat_lookup.sv
// Combinational op code -> fixed FP ALU latency in cycles (1..31).
module fp_lat_lookup
  import fp_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_FMA  = 5,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 14
) (
  input  logic [4:0] i_op,
  output logic [4:0] o_lat
);

  // Map each op class to its latency; anything unlisted is single-cycle
  always_comb begin
    o_lat = 5'd1;
    case (i_op)
      OP_ADD, OP_SUB, OP_MIN, OP_MAX,
      OP_CVT_W_S, OP_CVT_WU_S, OP_CVT_S_W, OP_CVT_S_WU: o_lat = 5'(LAT_ADD);
      OP_MUL:                                           o_lat = 5'(LAT_MUL);
      OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD:             o_lat = 5'(LAT_FMA);
      OP_DIV:                                           o_lat = 5'(LAT_DIV);
      OP_SQRT:                                          o_lat = 5'(LAT_SQRT);
      default:                                          o_lat = 5'd1;
    endcase
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Issues one FP ALU op at a time, counts out its fixed latency, captures the
// result/fflags and holds them for writeback. Flush kills any in-flight op.
module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_FMA  = 5,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic        issue_to_int,
  input  logic        flush,
  output logic        alu_start,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [4:0]  alu_fflags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_to_int,
  output logic [4:0]  wb_fflags,
  output logic        busy
);

  seq_state_t  r_state;
  logic [4:0]  r_cnt;
  logic [4:0]  r_alu_op;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_to_int;
  logic [4:0]  r_wb_fflags;

  logic [4:0]  w_lat;
  logic        w_fire;
  logic        w_capture;

  fp_lat_lookup #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_FMA  (LAT_FMA),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT)
  ) u_lat (
    .i_op  (issue_op),
    .o_lat (w_lat)
  );

  // Handshake and capture qualifiers; flush masks both the issue and the capture
  always_comb begin
    issue_ready = (r_state == ST_IDLE) && !flush;
    w_fire      = issue_valid && issue_ready && !reset;
    w_capture   = (r_state == ST_EXEC) && (r_cnt == 5'd0) && !flush;
    alu_start   = w_fire;
    // present the new op code in the start cycle, the latched one afterwards
    alu_op      = w_fire ? issue_op : r_alu_op;
    wb_valid    = (r_state == ST_DONE) && !flush;
    busy        = (r_state != ST_IDLE);
    wb_data     = r_wb_data;
    wb_rd       = r_wb_rd;
    wb_to_int   = r_wb_to_int;
    wb_fflags   = r_wb_fflags;
  end

  // FSM and latency counter; counter holds at zero rather than wrapping
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state <= ST_EXEC;
            r_cnt   <= w_lat - 5'd1;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 5'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        ST_DONE: begin
          if (wb_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Data registers: latched on issue / capture, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_op    <= '0;
      r_wb_rd     <= '0;
      r_wb_to_int <= 1'b0;
      r_wb_data   <= '0;
      r_wb_fflags <= '0;
    end else begin
      if (w_fire) begin
        r_alu_op    <= issue_op;
        r_wb_rd     <= issue_rd;
        r_wb_to_int <= issue_to_int;
      end
      if (w_capture) begin
        r_wb_data   <= alu_result;
        r_wb_fflags <= alu_fflags;
      end
    end
  end

endmodule
